// File: rtl/axil_up_master_pkg.sv
// Shared definitions for the AXI-Lite to up-bus bridge: channel state
// encoding, response codes, read-timeout fill pattern and default timeout.
package axil_up_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } chan_state_t;

    localparam logic [1:0]  RESP_OKAY           = 2'b00;
    localparam logic [1:0]  RESP_SLVERR         = 2'b10;
    localparam logic [31:0] RD_TIMEOUT_DATA     = 32'hDEAD_DEAD;
    localparam int          TIMEOUT_CYCLES_DFLT = 255;

endpackage

// File: rtl/axil_up_master_up_req_channel.sv
// One up-bus request path: IDLE->REQ->WAIT->RESP, 1-cycle req pulse after accept, response held
// until i_rsp_rdy; a WAIT that reaches TIMEOUT_CYCLES without ack answers SLVERR with i_to_dat.
module up_req_channel
    import axil_up_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [13:0] i_addr,
    input  logic [31:0] i_req_dat,
    input  logic        i_ack,
    input  logic [31:0] i_ack_dat,
    input  logic [31:0] i_to_dat,
    input  logic        i_rsp_rdy,
    output logic        o_idle,
    output logic        o_req,
    output logic [13:0] o_addr,
    output logic [31:0] o_dat,
    output logic        o_rsp_vld,
    output logic [1:0]  o_rsp
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    chan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic [13:0]      r_addr;
    logic [31:0]      r_dat;
    logic             r_rsp_vld;
    logic [1:0]       r_rsp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_dat     <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp     <= RESP_OKAY;
        end else begin
            r_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= i_addr;
                        r_dat   <= i_req_dat;
                        r_cnt   <= '0;
                    end
                end
                ST_REQ: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Ack is checked first so an ack on the final wait cycle still wins.
                    if (i_ack) begin
                        r_state   <= ST_RESP;
                        r_dat     <= i_ack_dat;
                        r_rsp     <= RESP_OKAY;
                        r_rsp_vld <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_RESP;
                        r_dat     <= i_to_dat;
                        r_rsp     <= RESP_SLVERR;
                        r_rsp_vld <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_rdy) begin
                        r_state   <= ST_IDLE;
                        r_rsp_vld <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_idle    = (r_state == ST_IDLE);
    assign o_req     = r_req;
    assign o_addr    = r_addr;
    assign o_dat     = r_dat;
    assign o_rsp_vld = r_rsp_vld;
    assign o_rsp     = r_rsp;

endmodule

// File: rtl/axil_up_master.sv
// AXI-Lite slave to up-bus master bridge with independent write/read paths, one outstanding each.
// Handshake-to-response is 3 cycles with a 1-cycle ack; ready is withheld until the path is idle.
module axil_up_master
    import axil_up_master_pkg::*;
#(
    parameter int AXI_ADDRESS_WIDTH = 16,
    parameter int TIMEOUT_CYCLES    = TIMEOUT_CYCLES_DFLT
) (
    input  logic                         up_clk,
    input  logic                         up_rstn,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_awaddr,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    input  logic [31:0]                  s_axi_wdata,
    input  logic [3:0]                   s_axi_wstrb,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    output logic [1:0]                   s_axi_bresp,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_araddr,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [31:0]                  s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         up_wreq,
    output logic [13:0]                  up_waddr,
    output logic [31:0]                  up_wdata,
    input  logic                         up_wack,
    output logic                         up_rreq,
    output logic [13:0]                  up_raddr,
    input  logic [31:0]                  up_rdata,
    input  logic                         up_rack
);

    logic        w_wr_idle;
    logic        w_rd_idle;
    logic        w_wr_accept;
    logic        w_rd_accept;
    logic [31:0] w_wr_dat;
    logic [31:0] w_rd_dat;
    logic        w_unused;

    // Readies are gated by reset so an idle-in-reset path never advertises acceptance.
    assign w_wr_accept   = up_rstn & w_wr_idle & s_axi_awvalid & s_axi_wvalid;
    assign w_rd_accept   = up_rstn & w_rd_idle & s_axi_arvalid;
    assign s_axi_awready = w_wr_accept;
    assign s_axi_wready  = w_wr_accept;
    assign s_axi_arready = w_rd_accept;

    assign up_wdata    = w_wr_dat;
    assign s_axi_rdata = w_rd_dat;
    assign w_unused    = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    up_req_channel #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wr_chan (
        .clk       (up_clk),
        .rst_n     (up_rstn),
        .i_start   (w_wr_accept),
        .i_addr    (s_axi_awaddr[15:2]),
        .i_req_dat (s_axi_wdata),
        .i_ack     (up_wack),
        .i_ack_dat (w_wr_dat),
        .i_to_dat  (w_wr_dat),
        .i_rsp_rdy (s_axi_bready),
        .o_idle    (w_wr_idle),
        .o_req     (up_wreq),
        .o_addr    (up_waddr),
        .o_dat     (w_wr_dat),
        .o_rsp_vld (s_axi_bvalid),
        .o_rsp     (s_axi_bresp)
    );

    up_req_channel #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd_chan (
        .clk       (up_clk),
        .rst_n     (up_rstn),
        .i_start   (w_rd_accept),
        .i_addr    (s_axi_araddr[15:2]),
        .i_req_dat (w_rd_dat),
        .i_ack     (up_rack),
        .i_ack_dat (up_rdata),
        .i_to_dat  (RD_TIMEOUT_DATA),
        .i_rsp_rdy (s_axi_rready),
        .o_idle    (w_rd_idle),
        .o_req     (up_rreq),
        .o_addr    (up_raddr),
        .o_dat     (w_rd_dat),
        .o_rsp_vld (s_axi_rvalid),
        .o_rsp     (s_axi_rresp)
    );

endmodule

// File: tb/tb_axil_up_master.sv
// Directed bench for axil_up_master: drives inputs just after the falling edge, samples there too.
module tb_axil_up_master;

    logic        up_clk = 1'b0;
    logic        up_rstn;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [15:0] s_axi_awaddr;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [15:0] s_axi_araddr;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        up_wreq;
    logic [13:0] up_waddr;
    logic [31:0] up_wdata;
    logic        up_wack;
    logic        up_rreq;
    logic [13:0] up_raddr;
    logic [31:0] up_rdata;
    logic        up_rack;

    int n_assert = 0;
    int n_fail   = 0;

    wire [102:0] w_all_out = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                              s_axi_rvalid, up_wreq, up_rreq, up_waddr, up_raddr, up_wdata,
                              s_axi_rdata, s_axi_bresp, s_axi_rresp};

    always #5 up_clk = ~up_clk;

    axil_up_master #(
        .AXI_ADDRESS_WIDTH (16),
        .TIMEOUT_CYCLES    (255)
    ) dut (
        .up_clk        (up_clk),
        .up_rstn       (up_rstn),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .up_wreq       (up_wreq),
        .up_waddr      (up_waddr),
        .up_wdata      (up_wdata),
        .up_wack       (up_wack),
        .up_rreq       (up_rreq),
        .up_raddr      (up_raddr),
        .up_rdata      (up_rdata),
        .up_rack       (up_rack)
    );

    task automatic test_reset();
        up_rstn = 1'b0;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        s_axi_awaddr = 16'hFFFF; s_axi_araddr = 16'hFFFF; s_axi_wdata = 32'hFFFF_FFFF;
        s_axi_wstrb = 4'hF; s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        up_wack = 1'b0; up_rack = 1'b0; up_rdata = 32'h0;
        repeat (2) @(negedge up_clk);
        #1;
        n_assert++;
        if (w_all_out !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", w_all_out);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(negedge up_clk);
        up_rstn = 1'b1;
        @(negedge up_clk);
        n_assert++;
        if (w_all_out !== '0) begin
            n_fail++; $display("FAIL post_reset_idle: got %h expected 0", w_all_out);
        end
    endtask

    task automatic test_write();
        s_axi_awaddr = 16'h0048; s_axi_wdata = 32'h1234_5678;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        #1;
        n_assert++;
        if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
            n_fail++; $display("FAIL wr_accept: got %b expected 11", {s_axi_awready, s_axi_wready});
        end
        @(negedge up_clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n_assert++;
        if ({up_wreq, up_waddr, up_wdata, s_axi_bvalid} !== {1'b1, 14'h012, 32'h1234_5678, 1'b0}) begin
            n_fail++; $display("FAIL wr_req: got req=%b addr=%h data=%h bvalid=%b expected 1 012 12345678 0",
                               up_wreq, up_waddr, up_wdata, s_axi_bvalid);
        end
        @(negedge up_clk);
        n_assert++;
        if ({up_wreq, s_axi_bvalid} !== 2'b00) begin
            n_fail++; $display("FAIL wr_pulse_single: got req/bvalid=%b expected 00", {up_wreq, s_axi_bvalid});
        end
        up_wack = 1'b1;
        @(negedge up_clk);
        up_wack = 1'b0;
        n_assert++;
        if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
            n_fail++; $display("FAIL wr_bvalid_lat3: got bvalid=%b bresp=%b expected 1 00", s_axi_bvalid, s_axi_bresp);
        end
        @(negedge up_clk);
        n_assert++;
        if (s_axi_bvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_bvalid_drop: got %b expected 0", s_axi_bvalid);
        end
    endtask

    task automatic test_read_backpressure();
        s_axi_araddr = 16'h0000; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        #1;
        n_assert++;
        if (s_axi_arready !== 1'b1) begin
            n_fail++; $display("FAIL rd_accept: got %b expected 1", s_axi_arready);
        end
        @(negedge up_clk);
        s_axi_arvalid = 1'b0;
        n_assert++;
        if ({up_rreq, up_raddr} !== {1'b1, 14'h000}) begin
            n_fail++; $display("FAIL rd_req: got req=%b addr=%h expected 1 000", up_rreq, up_raddr);
        end
        @(negedge up_clk);
        up_rdata = 32'h0005_0063; up_rack = 1'b1;
        @(negedge up_clk);
        up_rack = 1'b0; up_rdata = 32'hFFFF_FFFF;
        n_assert++;
        if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'h0005_0063}) begin
            n_fail++; $display("FAIL rd_resp: got rvalid=%b rresp=%b rdata=%h expected 1 00 00050063",
                               s_axi_rvalid, s_axi_rresp, s_axi_rdata);
        end
        s_axi_arvalid = 1'b1;
        #1;
        n_assert++;
        if (s_axi_arready !== 1'b0) begin
            n_fail++; $display("FAIL rd_busy_arready: got %b expected 0", s_axi_arready);
        end
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge up_clk);
            n_assert++;
            if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'h0005_0063}) begin
                n_fail++; $display("FAIL rd_hold_%0d: got rvalid=%b rresp=%b rdata=%h expected 1 00 00050063",
                                   i, s_axi_rvalid, s_axi_rresp, s_axi_rdata);
            end
        end
        s_axi_rready = 1'b1;
        @(negedge up_clk);
        s_axi_rready = 1'b0;
        n_assert++;
        if (s_axi_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rd_rvalid_drop: got %b expected 0", s_axi_rvalid);
        end
    endtask

    task automatic test_write_timeout();
        bit early;
        s_axi_bready = 1'b0;
        s_axi_awaddr = 16'h0100; s_axi_wdata = 32'hA5A5_A5A5;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge up_clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n_assert++;
        if ({up_wreq, up_waddr} !== {1'b1, 14'h040}) begin
            n_fail++; $display("FAIL wto_req: got req=%b addr=%h expected 1 040", up_wreq, up_waddr);
        end
        early = 1'b0;
        repeat (255) begin
            @(negedge up_clk);
            if (s_axi_bvalid !== 1'b0) early = 1'b1;
        end
        n_assert++;
        if (early !== 1'b0) begin
            n_fail++; $display("FAIL wto_early_bvalid: got %b expected 0", early);
        end
        @(negedge up_clk);
        n_assert++;
        if ({s_axi_bvalid, s_axi_bresp} !== 3'b110) begin
            n_fail++; $display("FAIL wto_slverr: got bvalid=%b bresp=%b expected 1 10", s_axi_bvalid, s_axi_bresp);
        end
        s_axi_bready = 1'b1;
        @(negedge up_clk);
        s_axi_bready = 1'b0;
        up_wack = 1'b1;
        @(negedge up_clk);
        up_wack = 1'b0;
        @(negedge up_clk);
        n_assert++;
        if ({s_axi_bvalid, up_wreq} !== 2'b00) begin
            n_fail++; $display("FAIL wto_late_ack: got bvalid/wreq=%b expected 00", {s_axi_bvalid, up_wreq});
        end
    endtask

    task automatic test_read_timeout();
        bit early;
        s_axi_rready = 1'b0;
        s_axi_araddr = 16'h0204; s_axi_arvalid = 1'b1;
        @(negedge up_clk);
        s_axi_arvalid = 1'b0;
        n_assert++;
        if ({up_rreq, up_raddr} !== {1'b1, 14'h081}) begin
            n_fail++; $display("FAIL rto_req: got req=%b addr=%h expected 1 081", up_rreq, up_raddr);
        end
        early = 1'b0;
        repeat (255) begin
            @(negedge up_clk);
            if (s_axi_rvalid !== 1'b0) early = 1'b1;
        end
        n_assert++;
        if (early !== 1'b0) begin
            n_fail++; $display("FAIL rto_early_rvalid: got %b expected 0", early);
        end
        @(negedge up_clk);
        n_assert++;
        if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b10, 32'hDEAD_DEAD}) begin
            n_fail++; $display("FAIL rto_slverr: got rvalid=%b rresp=%b rdata=%h expected 1 10 deaddead",
                               s_axi_rvalid, s_axi_rresp, s_axi_rdata);
        end
        s_axi_rready = 1'b1;
        @(negedge up_clk);
        s_axi_rready = 1'b0;
        s_axi_araddr = 16'h0010; s_axi_arvalid = 1'b1;
        @(negedge up_clk);
        s_axi_arvalid = 1'b0;
        repeat (255) @(negedge up_clk);
        n_assert++;
        if (s_axi_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rlim_rvalid_before: got %b expected 0", s_axi_rvalid);
        end
        up_rack = 1'b1; up_rdata = 32'hCAFE_F00D;
        @(negedge up_clk);
        up_rack = 1'b0; up_rdata = 32'h0;
        n_assert++;
        if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL rlim_ack_wins: got rvalid=%b rresp=%b rdata=%h expected 1 00 cafef00d",
                               s_axi_rvalid, s_axi_rresp, s_axi_rdata);
        end
        s_axi_rready = 1'b1;
        @(negedge up_clk);
        s_axi_rready = 1'b0;
        n_assert++;
        if (s_axi_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rlim_rvalid_drop: got %b expected 0", s_axi_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        s_axi_awaddr = 16'h0ABC; s_axi_wdata = 32'h0BAD_BEEF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge up_clk);
            #1;
            n_assert++;
            if ({s_axi_awready, s_axi_wready, up_wreq} !== 3'b000) begin
                n_fail++; $display("FAIL aw_only_%0d: got awready/wready/wreq=%b expected 000",
                                   i, {s_axi_awready, s_axi_wready, up_wreq});
            end
        end
        s_axi_wvalid = 1'b1; s_axi_araddr = 16'h0030; s_axi_arvalid = 1'b1;
        #1;
        n_assert++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            n_fail++; $display("FAIL dual_accept: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        @(negedge up_clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        n_assert++;
        if ({up_wreq, up_rreq, up_waddr, up_raddr, up_wdata} !== {2'b11, 14'h2AF, 14'h00C, 32'h0BAD_BEEF}) begin
            n_fail++; $display("FAIL dual_req: got reqs=%b waddr=%h raddr=%h wdata=%h expected 11 2af 00c 0badbeef",
                               {up_wreq, up_rreq}, up_waddr, up_raddr, up_wdata);
        end
        @(negedge up_clk);
        up_wack = 1'b1; up_rack = 1'b1; up_rdata = 32'h1111_2222;
        @(negedge up_clk);
        up_wack = 1'b0; up_rack = 1'b0;
        n_assert++;
        if ({s_axi_bvalid, s_axi_rvalid, s_axi_rdata} !== {2'b11, 32'h1111_2222}) begin
            n_fail++; $display("FAIL dual_resp: got b/rvalid=%b rdata=%h expected 11 11112222",
                               {s_axi_bvalid, s_axi_rvalid}, s_axi_rdata);
        end
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(negedge up_clk);
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        n_assert++;
        if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL dual_drop: got %b expected 00", {s_axi_bvalid, s_axi_rvalid});
        end
    endtask

    task automatic test_reset_mid_wait();
        s_axi_awaddr = 16'h0008; s_axi_wdata = 32'h0000_0055;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge up_clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge up_clk);
        up_rstn = 1'b0;
        #1;
        n_assert++;
        if (w_all_out !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", w_all_out);
        end
        repeat (2) @(negedge up_clk);
        up_rstn = 1'b1; up_wack = 1'b1;
        @(negedge up_clk);
        up_wack = 1'b0;
        @(negedge up_clk);
        n_assert++;
        if ({s_axi_bvalid, up_wreq} !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset_no_resp: got bvalid/wreq=%b expected 00", {s_axi_bvalid, up_wreq});
        end
        s_axi_awaddr = 16'h0014; s_axi_wdata = 32'h0000_0009;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        @(negedge up_clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n_assert++;
        if ({up_wreq, up_waddr, up_wdata} !== {1'b1, 14'h005, 32'h0000_0009}) begin
            n_fail++; $display("FAIL post_reset_req: got req=%b addr=%h data=%h expected 1 005 00000009",
                               up_wreq, up_waddr, up_wdata);
        end
        @(negedge up_clk);
        up_wack = 1'b1;
        @(negedge up_clk);
        up_wack = 1'b0;
        n_assert++;
        if ({s_axi_bvalid, s_axi_bresp} !== 3'b100) begin
            n_fail++; $display("FAIL post_reset_resp: got bvalid=%b bresp=%b expected 1 00", s_axi_bvalid, s_axi_bresp);
        end
        @(negedge up_clk);
        s_axi_bready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_backpressure();
        test_write_timeout();
        test_read_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
